// File: rtl/binary2bcd_seq.sv
// -----------------------------------------------------------------------------
// binary2bcd_seq
// Iterative binary-to-BCD converter using the double-dabble (shift-and-add-3)
// algorithm. One operand bit is consumed per clock, so a conversion takes
// WIDTH cycles in SHIFT, followed by a one-cycle DONE state.
//
// Parameters
//   WIDTH   binary operand width (4..32)
//   DIGITS  number of BCD digits produced (1..10)
//
// Ports
//   clk     rising-edge clock
//   rst     synchronous, active-high reset
//   start   conversion request, accepted in IDLE or DONE only
//   din     binary operand, captured on the accepting edge
//   busy    high while the FSM is in SHIFT
//   done    one-cycle pulse marking bcd/ovf/sign valid
//   bcd     result digits, digit k in bits [4k+3:4k]
//   ovf     decimal value needed more than DIGITS digits (bcd holds value mod 10^DIGITS)
//   sign    negative-operand flag
//
// Build option
//   BINARY2BCD_SIGNED_EN  when defined, din is two's complement: sign takes the
//                         MSB and the magnitude is converted. When undefined,
//                         din is unsigned and sign is tied to 0.
// -----------------------------------------------------------------------------
module binary2bcd_seq #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      din,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  ovf,
    output logic                  sign
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next;

    logic [CW-1:0]      r_cnt;
    logic [BW-1:0]      r_work;
    logic [WIDTH-1:0]   r_op;
    logic               r_sticky;
    logic [BW-1:0]      r_bcd;
    logic               r_ovf;

    logic               w_accept;
    logic               w_last;
    logic [BW-1:0]      w_adj;
    logic               w_carry;
    logic [BW-1:0]      w_work_nxt;
    logic [WIDTH-1:0]   w_op_nxt;
    logic [WIDTH-1:0]   w_mag;

    // Add 3 to every digit >= 5 so that the following left shift carries
    // correctly into the next decimal digit.
    function automatic logic [BW-1:0] dabble_adjust(input logic [BW-1:0] work);
        logic [BW-1:0] res;
        res = work;
        for (int k = 0; k < DIGITS; k++) begin
            if (work[4*k +: 4] >= 4'd5) begin
                res[4*k +: 4] = work[4*k +: 4] + 4'd3;
            end
        end
        return res;
    endfunction

    assign w_accept = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_last   = (r_cnt == CW'(1));
    assign w_adj    = dabble_adjust(r_work);
    // The bit leaving the top digit is lost from bcd; it feeds the sticky overflow.
    assign w_carry  = w_adj[BW-1];
    assign {w_work_nxt, w_op_nxt} = {w_adj[BW-2:0], r_op, 1'b0};

`ifdef BINARY2BCD_SIGNED_EN
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic r_sign_work;
    logic r_sign;

    // Negating the most negative value wraps to itself, which read as unsigned
    // is exactly its magnitude 2^(WIDTH-1).
    assign w_mag = din[WIDTH-1] ? (~din + ONE) : din;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sign_work <= 1'b0;
            r_sign      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_sign_work <= din[WIDTH-1];
            end else if ((r_state == SHIFT) && w_last) begin
                r_sign <= r_sign_work;
            end
        end
    end

    assign sign = r_sign;
`else
    assign w_mag = din;
    assign sign  = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = SHIFT;
            SHIFT:   if (w_last) w_next = DONE;
            DONE:    w_next = start ? SHIFT : IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Datapath: load on accept, shift while in SHIFT, publish on the last shift
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_work   <= '0;
            r_op     <= '0;
            r_sticky <= 1'b0;
            r_bcd    <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op     <= w_mag;
                r_work   <= '0;
                r_sticky <= 1'b0;
                r_cnt    <= CW'(WIDTH);
            end else if (r_state == SHIFT) begin
                r_op     <= w_op_nxt;
                r_work   <= w_work_nxt;
                r_sticky <= r_sticky | w_carry;
                r_cnt    <= r_cnt - CW'(1);
                if (w_last) begin
                    r_bcd <= w_work_nxt;
                    r_ovf <= r_sticky | w_carry;
                end
            end
        end
    end

    assign busy = (r_state == SHIFT);
    assign done = (r_state == DONE);
    assign bcd  = r_bcd;
    assign ovf  = r_ovf;

endmodule

// File: doc/binary2bcd_seq.md
BINARY2BCD_SEQ -- requirements
Module: binary2bcd_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8, binary input width in bits (legal range 4..32).
REQ-002 SHALL have parameter DIGITS, default 3, number of BCD output digits (legal range 1..10).
REQ-003 SHALL have port clk  input  1  rising-edge clock, the only clock.
REQ-004 SHALL have port rst  input  1  reset, synchronous to clk and active-high.
REQ-005 SHALL have port start  input  1  request to convert din; sampled on the rising edge of clk.
REQ-006 SHALL have port din  input  WIDTH  binary operand; sampled only on the edge that accepts start.
REQ-007 SHALL have port busy  output  1  conversion in progress.
REQ-008 SHALL have port done  output  1  one-cycle pulse that marks valid bcd/ovf/sign.
REQ-009 SHALL have port bcd  output  4*DIGITS  result, digit 0 in bits [3:0], digit k in bits [4k+3:4k].
REQ-010 SHALL have port ovf  output  1  set when the decimal value needs more than DIGITS digits.
REQ-011 SHALL have port sign  output  1  negative-operand flag (see Configuration).

Function
REQ-012 SHALL implement an iterative double-dabble FSM with three states: IDLE, SHIFT and DONE.
REQ-013 SHALL accept start only in IDLE or DONE; the accepting edge loads din and a shift counter of WIDTH, clears the working BCD register and the sticky overflow, and enters SHIFT.
REQ-014 In SHIFT, each cycle SHALL add 3 to every working digit >= 5, then shift {bcd_work, operand} left by 1 bit, then decrement the counter.
REQ-015 SHALL OR-accumulate into a sticky overflow any 1 bit shifted out of the top working digit.
REQ-016 SHALL go from SHIFT to DONE on the edge that performs the WIDTH-th shift, and on that same edge SHALL copy the working register to bcd and the sticky overflow to ovf.
REQ-017 Latency: done SHALL be high for exactly one cycle, WIDTH clock edges after the start-accepting edge.
REQ-018 DONE SHALL return to IDLE on the next edge, unless start is high on that edge, in which case a new conversion is accepted (back-to-back throughput of WIDTH+1 cycles per result).
REQ-019 busy SHALL be 1 exactly while the FSM is in SHIFT.
REQ-020 start in SHIFT SHALL be ignored: no restart, no queueing, and no change to the in-flight result.
REQ-021 bcd, ovf and sign SHALL hold their last completed values until the next DONE and SHALL NOT toggle during SHIFT.
REQ-022 On overflow, bcd SHALL equal the value mod 10^DIGITS, every digit SHALL be 0..9, and ovf SHALL be 1.
REQ-023 din = 0 SHALL still take the full WIDTH cycles and produce all-zero bcd with ovf = 0.

Reset
REQ-024 rst high on a rising edge SHALL force IDLE, counter 0, working register 0, bcd 0, ovf 0, sign 0, busy 0 and done 0.
REQ-025 rst SHALL take priority over start; a conversion interrupted by rst SHALL be abandoned with no done pulse.
REQ-026 The first start accepted after rst deasserts SHALL behave identically to a start accepted after power-up.

Configuration
REQ-027 Macro BINARY2BCD_SIGNED_EN: when defined, din SHALL be treated as two's complement.
  - On the accepting edge, sign captures din[WIDTH-1] and the magnitude |din| is converted.
  - The most negative value -2^(WIDTH-1) SHALL convert correctly as an unsigned magnitude.
  - sign SHALL update at DONE together with bcd.
REQ-028 Without BINARY2BCD_SIGNED_EN: din SHALL be treated as unsigned, sign SHALL be constant 0, and no negation logic SHALL be synthesised.

Verification
REQ-029 Bench (WIDTH=8, DIGITS=3, unsigned) SHALL cover:
  - start with din = 0, 9, 10, 99, 123, 255 -> bcd = 0x000, 0x009, 0x010, 0x099, 0x123, 0x255, ovf = 0, done exactly 8 edges after each start edge.
REQ-030 Bench (WIDTH=8, DIGITS=2) SHALL cover:
  - din = 123 -> bcd = 0x23, ovf = 1.
  - din = 99 -> bcd = 0x99, ovf = 0.
REQ-031 Bench SHALL cover start pulses while busy:
  - din = 47 accepted; start with din = 200 held for cycles 2..5 -> a single done, bcd = 0x047.
  - start held continuously -> one result every 9 cycles.
REQ-032 Bench SHALL cover reset mid-conversion:
  - rst at cycle 4 of din = 255 -> no done; bcd = 0x000, busy = 0 on the next cycle.
  - next start with din = 5 -> bcd = 0x005.
REQ-033 Bench SHALL cover signed mode (BINARY2BCD_SIGNED_EN, WIDTH=8, DIGITS=3):
  - din = -128 -> sign = 1, bcd = 0x128.
  - din = -1 -> sign = 1, bcd = 0x001.
  - din = 127 -> sign = 0, bcd = 0x127.
REQ-034 Bench SHALL run a self-check sweep of all 256 din values against a reference model in both macro builds, with zero mismatches.
